display_scan_controller: RTL and testbench
==========================================

// Module: display_scan_controller
// PURPOSE
//   Time-multiplexing scan stage for the 4-digit 7-segment display. Sits directly upstream
//   of anode_decoder and the segment decoder. Drives digit_sel[1:0] into anode_decoder and
//   the matching 4-bit nibble into the segment decoder. Rotates digits at a fixed refresh
//   rate. Double-buffers the displayed value so a frame never shows mixed old/new digits.
// PARAMETERS
//   REFRESH_DIV  100_000  clk cycles per digit slot (1 kHz/digit at 100 MHz); must be >= 2
//   DEAD_CYCLES  16       blanking cycles after each digit change (DEAD_TIME_EN only); 1..REFRESH_DIV-1
// PORTS
//   clk         in   1   system clock; the only clock, all state on posedge
//   reset       in   1   synchronous, active-high reset
//   value_in    in   16  four hex nibbles; [3:0] is digit 0, [15:12] is digit 3
//   digit_en_in in   4   per-digit enable mask, bit n enables digit n
//   load        in   1   1-cycle strobe: capture value_in/digit_en_in into the shadow buffer
//   digit_sel   out  2   current digit number, to anode_decoder.switch_in
//   nibble_out  out  4   value of the current digit, to the segment decoder
//   blank       out  1   1 = suppress the current digit (top level forces all anodes HIGH)
//   tick        out  1   1-cycle pulse on the cycle the slot counter wraps
// BEHAVIOUR
//   Reset values: prescaler=0, digit_sel=0, shadow/active value=0, shadow/active enable=4'b0000,
//     pending=0, tick=0. With active enable=0, blank=1 and nibble_out=0, so all digits are dark
//     until the first load takes effect.
//   Prescaler counts 0..REFRESH_DIV-1. tick=1 when count==REFRESH_DIV-1. On that edge count<=0
//     and digit_sel<=digit_sel+1 (mod 4, 3 wraps to 0).
//   nibble_out = active_value[4*digit_sel +: 4]; blank = ~active_en[digit_sel] (plus dead time below).
//     Both are combinational from registers, so they are aligned with digit_sel in the same cycle.
//   load: shadow<=inputs and pending<=1. Repeated loads before a swap overwrite the shadow; last wins.
//   Frame swap: tick while digit_sel==3 and pending=1 -> active<=shadow, pending<=0. The new
//     value appears with digit_sel=0. A swap never occurs at any other digit_sel value.
//   load in the same cycle as a swap tick: value_in/digit_en_in bypass straight to active.
//     pending ends at 0 and no frame is lost.
//   reset mid-scan: everything returns to the reset values on the next edge; a pending load is discarded.
//   Prescaler width = $clog2(REFRESH_DIV). No other arithmetic; every counter wraps explicitly.
// CONFIGURATION
//   DISPLAY_DEAD_TIME_EN defined: a 2-state FSM (SCAN, DEAD) is added for anti-ghosting.
//     - Reset state is SCAN.
//     - tick moves SCAN->DEAD and loads a dead counter with DEAD_CYCLES-1.
//     - In DEAD, blank=1 regardless of the enables; the counter decrements.
//     - At counter 0, DEAD->SCAN.
//     - A tick arriving while in DEAD restarts the dead counter.
//   Undefined: no FSM, no dead counter; blank = ~active_en[digit_sel] only; DEAD_CYCLES is ignored.
// STRUCTURE
//   display_pkg: DIGIT_W=2, NIBBLE_W=4, NUM_DIGITS=4; typedef digit_t (logic[1:0]),
//     nibble_t (logic[3:0]), scan_state_t enum {SCAN, DEAD}. Shared with anode_decoder and the
//     segment decoder top level.
//   Sub-module refresh_prescaler (param DIV; ports clk, reset, tick) provides the slot counter.
//     The scan/buffer logic stays in this module.
// TESTING  (REFRESH_DIV=4, DEAD_CYCLES=1 unless noted)
//   1 Reset held 3 cycles mid-scan -> digit_sel=0, nibble_out=0, blank=1, tick=0; a prior pending load is dropped.
//   2 load value_in=16'h1234, digit_en_in=4'hF while digit_sel=1 -> still dark until the 3->0 wrap;
//     then digit_sel 0/1/2/3 shows nibble 4/3/2/1, blank=0, 4 cycles per digit, tick every 4 cycles.
//   3 With 16'h1234 active, load 16'hABCD at digit_sel=1 -> digits 1..3 still show 3,2,1;
//     the next frame shows D,C,B,A.
//   4 load 16'h5678 in the exact cycle of the digit_sel=3 tick -> digit_sel=0 shows 8 on the next
//     cycle; pending=0 afterwards.
//   5 digit_en_in=4'b0011 -> blank=1 exactly while digit_sel is 2 or 3; blank=0 while it is 0 or 1.
//   6 DISPLAY_DEAD_TIME_EN defined -> blank=1 for exactly 1 cycle after each digit_sel change,
//     then 0 for 3 cycles; without the macro blank never pulses.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit 7-segment display path
// (scan controller, anode decoder, segment decoder).
package display_pkg;

  localparam int DIGIT_W    = 2;
  localparam int NIBBLE_W   = 4;
  localparam int NUM_DIGITS = 4;

  typedef logic [DIGIT_W-1:0]  digit_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;

  typedef enum logic {SCAN, DEAD} scan_state_t;

  // Digit rotation: 0,1,2,3,0,... with an explicit wrap.
  function automatic digit_t next_digit(digit_t d);
    return (d == digit_t'(NUM_DIGITS - 1)) ? '0 : d + digit_t'(1);
  endfunction

endpackage

// File: rtl/display_scan_controller_prescaler.sv
// Slot counter for the display scan: counts 0..DIV-1 and pulses tick on the
// last count of every slot.
module refresh_prescaler #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Digit scan stage with a double-buffered display value. Optional anti-ghosting
// dead time after each digit change is enabled by defining DISPLAY_DEAD_TIME_EN.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic [3:0]  digit_en_in,
  input  logic        load,
  output logic [1:0]  digit_sel,
  output logic [3:0]  nibble_out,
  output logic        blank,
  output logic        tick
);

  nibble_t [NUM_DIGITS-1:0] active_value;
  nibble_t [NUM_DIGITS-1:0] shadow_value;
  logic    [NUM_DIGITS-1:0] active_en;
  logic    [NUM_DIGITS-1:0] shadow_en;
  logic                     pending;
  logic                     swap;
  logic                     en_blank;

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Frame boundary: the wrap out of the last digit.
  assign swap = tick && (digit_sel == digit_t'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_sel    <= '0;
      active_value <= '0;
      active_en    <= '0;
      shadow_value <= '0;
      shadow_en    <= '0;
      pending      <= 1'b0;
    end else begin
      if (tick) begin
        digit_sel <= next_digit(digit_sel);
      end
      if (load) begin
        shadow_value <= value_in;
        shadow_en    <= digit_en_in;
      end
      // A load coinciding with the swap bypasses the shadow so it is not held a frame.
      if (swap && load) begin
        active_value <= value_in;
        active_en    <= digit_en_in;
        pending      <= 1'b0;
      end else if (swap && pending) begin
        active_value <= shadow_value;
        active_en    <= shadow_en;
        pending      <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  assign nibble_out = active_value[digit_sel];
  assign en_blank   = ~active_en[digit_sel];

`ifdef DISPLAY_DEAD_TIME_EN
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  scan_state_t   scan_state, scan_state_nxt;
  logic [DW-1:0] dead_cnt, dead_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_state <= SCAN;
      dead_cnt   <= '0;
    end else begin
      scan_state <= scan_state_nxt;
      dead_cnt   <= dead_cnt_nxt;
    end
  end

  always_comb begin
    scan_state_nxt = scan_state;
    dead_cnt_nxt   = dead_cnt;
    case (scan_state)
      SCAN: begin
        if (tick) begin
          scan_state_nxt = DEAD;
          dead_cnt_nxt   = DW'(DEAD_CYCLES - 1);
        end
      end
      DEAD: begin
        if (tick) begin
          dead_cnt_nxt = DW'(DEAD_CYCLES - 1);
        end else if (dead_cnt == '0) begin
          scan_state_nxt = SCAN;
        end else begin
          dead_cnt_nxt = dead_cnt - DW'(1);
        end
      end
      default: scan_state_nxt = SCAN;
    endcase
  end

  assign blank = en_blank | (scan_state == DEAD);
`else
  assign blank = en_blank;
`endif

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with REFRESH_DIV=4, DEAD_CYCLES=1.
// Honours DISPLAY_DEAD_TIME_EN when the bundle is built with it.
module tb_display_scan_controller;

  localparam int NSLOT = 24;
  localparam int NROW  = NSLOT * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic [3:0]  digit_en_in;
  logic        load;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble_out;
  logic        blank;
  logic        tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        ld;
    logic [15:0] val;
    logic [3:0]  en;
    logic [1:0]  e_ds;
    logic [3:0]  e_nib;
    logic        e_blank;
    logic        e_tick;
    logic        dead;
  } vec_t;

  vec_t vecs[NROW];

  display_scan_controller #(.REFRESH_DIV(4), .DEAD_CYCLES(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .digit_en_in (digit_en_in),
    .load        (load),
    .digit_sel   (digit_sel),
    .nibble_out  (nibble_out),
    .blank       (blank),
    .tick        (tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One 4-cycle digit slot; dead marks the first cycle after a digit change.
  task automatic add_slot(int s, logic [1:0] ds, logic [3:0] nib, logic b, logic dead);
    for (int c = 0; c < 4; c++) begin
      vecs[4*s+c] = '{rst: 1'b0, ld: 1'b0, val: 16'h0, en: 4'h0, e_ds: ds, e_nib: nib,
                      e_blank: b, e_tick: (c == 3), dead: (dead && c == 0)};
    end
  endtask

  task automatic set_load(int row, logic [15:0] v, logic [3:0] e);
    vecs[row].ld  = 1'b1;
    vecs[row].val = v;
    vecs[row].en  = e;
  endtask

  function automatic logic exp_blank(logic b, logic dead);
`ifdef DISPLAY_DEAD_TIME_EN
    return b | dead;
`else
    return b;
`endif
  endfunction

  initial begin
    // dark until first frame swap; load 1234 at digit 1
    add_slot(0, 2'd0, 4'h0, 1'b1, 1'b0);
    add_slot(1, 2'd1, 4'h0, 1'b1, 1'b1);
    add_slot(2, 2'd2, 4'h0, 1'b1, 1'b1);
    add_slot(3, 2'd3, 4'h0, 1'b1, 1'b1);
    set_load(4, 16'h1234, 4'hF);
    // 1234 frame; ABCD loaded at digit 1 must not tear the frame
    add_slot(4, 2'd0, 4'h4, 1'b0, 1'b1);
    add_slot(5, 2'd1, 4'h3, 1'b0, 1'b1);
    add_slot(6, 2'd2, 4'h2, 1'b0, 1'b1);
    add_slot(7, 2'd3, 4'h1, 1'b0, 1'b1);
    set_load(20, 16'hABCD, 4'hF);
    // ABCD frame; 1111 pending, then 5678 loaded on the swap tick (last wins, bypass)
    add_slot(8,  2'd0, 4'hD, 1'b0, 1'b1);
    add_slot(9,  2'd1, 4'hC, 1'b0, 1'b1);
    add_slot(10, 2'd2, 4'hB, 1'b0, 1'b1);
    add_slot(11, 2'd3, 4'hA, 1'b0, 1'b1);
    set_load(44, 16'h1111, 4'hF);
    set_load(47, 16'h5678, 4'hF);
    // 5678 shown for two frames: nothing pending after the bypass
    for (int f = 0; f < 2; f++) begin
      add_slot(12+4*f, 2'd0, 4'h8, 1'b0, 1'b1);
      add_slot(13+4*f, 2'd1, 4'h7, 1'b0, 1'b1);
      add_slot(14+4*f, 2'd2, 4'h6, 1'b0, 1'b1);
      add_slot(15+4*f, 2'd3, 4'h5, 1'b0, 1'b1);
    end
    set_load(68, 16'h5678, 4'b0011);
    // enable mask 0011: digits 2,3 blanked
    add_slot(20, 2'd0, 4'h8, 1'b0, 1'b1);
    add_slot(21, 2'd1, 4'h7, 1'b0, 1'b1);
    add_slot(22, 2'd2, 4'h6, 1'b1, 1'b1);
    add_slot(23, 2'd3, 4'h5, 1'b1, 1'b1);

    reset       = 1'b1;
    load        = 1'b0;
    value_in    = 16'h0;
    digit_en_in = 4'h0;
    repeat (3) step();

    for (int i = 0; i < NROW; i++) begin
      check($sformatf("row%0d digit_sel", i), 16'(digit_sel), 16'(vecs[i].e_ds));
      check($sformatf("row%0d nibble", i), 16'(nibble_out), 16'(vecs[i].e_nib));
      check($sformatf("row%0d blank", i), 16'(blank), 16'(exp_blank(vecs[i].e_blank, vecs[i].dead)));
      check($sformatf("row%0d tick", i), 16'(tick), 16'(vecs[i].e_tick));
      reset       = vecs[i].rst;
      load        = vecs[i].ld;
      value_in    = vecs[i].val;
      digit_en_in = vecs[i].en;
      step();
    end

    // reset mid-scan with a load pending: the load must be discarded
    load        = 1'b1;
    value_in    = 16'h9999;
    digit_en_in = 4'hF;
    step();
    load = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      step();
      check($sformatf("rst%0d digit_sel", r), 16'(digit_sel), 16'h0);
      check($sformatf("rst%0d nibble", r), 16'(nibble_out), 16'h0);
      check($sformatf("rst%0d blank", r), 16'(blank), 16'h1);
      check($sformatf("rst%0d tick", r), 16'(tick), 16'h0);
    end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check($sformatf("post%0d digit_sel", c), 16'(digit_sel), 16'((c / 4) % 4));
      check($sformatf("post%0d nibble", c), 16'(nibble_out), 16'h0);
      check($sformatf("post%0d blank", c), 16'(blank), 16'h1);
      check($sformatf("post%0d tick", c), 16'(tick), 16'(c % 4 == 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
